ofm_writeback: RTL and testbench

//  Downstream of the CONV sub-top. Takes each 16-channel post-ReLU6 OFM pixel and buffers it in a small FIFO.

---
 rtl/ofm_writeback.sv | 194 +++++++++++++++++++
 tb/tb_ofm_writeback.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | ofm_writeback: buffers 16-channel OFM pixels, writes 4 words each (HWC).   |
// | Option: OFM_WB_CHECKSUM_EN adds a rotate-XOR checksum of written words.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ofm_writeback #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        OFM_W,
  input  logic [7:0]        OFM_C,
  input  logic              in_valid,
  input  logic [127:0]      ofm_bus,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              cfg_err
`ifdef OFM_WB_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] base_q;
  logic [3:0]        ng_q;
  logic [15:0]       np_q;
  logic [5:0]        stride_q;
  logic [19:0]       total_q;
  logic [19:0]       acc_q;

  logic [127:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [PTR_W:0]    cnt;

  logic              wr_act;
  logic [1:0]        k_q;
  logic [127:0]      pix_q;
  logic [15:0]       p_q;
  logic [3:0]        g_q;

  logic cfg_ok, start_go, all_acc, push, drop;
  logic w_free, fifo_pop, bypass, fifo_push, load, last_word;
  logic [127:0] load_data;
  logic [15:0]  w_np;

  assign cfg_ok   = (OFM_C != 8'd0) && (OFM_C[3:0] == 4'd0) && (OFM_W != 8'd0);
  assign start_go = start && (state != S_RUN);
  assign w_np     = 16'(OFM_W) * 16'(OFM_W);

  assign in_ready = (state == S_RUN) && (cnt != CNT_FULL);
  assign all_acc  = (acc_q == total_q);
  assign push     = in_valid && in_ready && !all_acc;
  assign drop     = (state == S_RUN) && in_valid && (!in_ready || all_acc);

  // An entry arriving while the FIFO is empty and the writer is free skips
  // the FIFO so its first word appears on the very next cycle.
  assign w_free    = !wr_act || (k_q == 2'd3);
  assign fifo_pop  = w_free && (cnt != '0) && (state == S_RUN);
  assign bypass    = w_free && (cnt == '0) && push;
  assign fifo_push = push && !bypass;
  assign load      = fifo_pop || bypass;
  assign load_data = fifo_pop ? mem[rptr] : ofm_bus;

  assign last_word = wr_act && (k_q == 2'd3) && (p_q == np_q - 16'd1) &&
                     (g_q == ng_q - 4'd1);

  assign wr_en   = wr_act;
  assign wr_data = pix_q[{k_q, 5'b00000} +: 32];
  assign wr_addr = base_q + (ADDR_W'(p_q) * ADDR_W'(stride_q)) +
                   ADDR_W'({g_q, 2'b00}) + ADDR_W'(k_q);
  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start && cfg_ok) state_n = S_RUN;
      S_RUN:   if (last_word)       state_n = S_DONE;
      S_DONE:  if (start && cfg_ok) state_n = S_RUN;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem[wptr] <= ofm_bus;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      ng_q     <= '0;
      np_q     <= '0;
      stride_q <= '0;
      total_q  <= '0;
      acc_q    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      wr_act   <= 1'b0;
      k_q      <= '0;
      pix_q    <= '0;
      p_q      <= '0;
      g_q      <= '0;
      overflow <= 1'b0;
      cfg_err  <= 1'b0;
`ifdef OFM_WB_CHECKSUM_EN
      checksum <= '0;
`endif
    end else if (start_go) begin
      if (cfg_ok) begin
        base_q   <= base_addr;
        ng_q     <= OFM_C[7:4];
        np_q     <= w_np;
        stride_q <= OFM_C[7:2];
        total_q  <= 20'(OFM_C[7:4]) * 20'(w_np);
        acc_q    <= '0;
        wptr     <= '0;
        rptr     <= '0;
        cnt      <= '0;
        wr_act   <= 1'b0;
        k_q      <= '0;
        p_q      <= '0;
        g_q      <= '0;
        overflow <= 1'b0;
        cfg_err  <= 1'b0;
`ifdef OFM_WB_CHECKSUM_EN
        checksum <= '0;
`endif
      end else begin
        cfg_err <= 1'b1;
      end
    end else begin
      if (drop)      overflow <= 1'b1;
      if (push)      acc_q    <= acc_q + 20'd1;
      if (fifo_push) wptr     <= wptr + 1'b1;
      if (fifo_pop)  rptr     <= rptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      if (wr_act) begin
        k_q <= k_q + 2'd1;
        if (k_q == 2'd3) begin
          if (p_q == np_q - 16'd1) begin
            p_q <= '0;
            g_q <= g_q + 4'd1;
          end else begin
            p_q <= p_q + 16'd1;
          end
        end
`ifdef OFM_WB_CHECKSUM_EN
        checksum <= {checksum[30:0], checksum[31]} ^ wr_data;
`endif
      end

      if (load) begin
        wr_act <= 1'b1;
        pix_q  <= load_data;
      end else if (w_free) begin
        wr_act <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ofm_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ofm_writeback: scoreboard bench for ofm_writeback.                      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ofm_writeback;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [7:0]   cfg_w = '0;
  logic [7:0]   cfg_c = '0;
  logic         in_valid = 1'b0;
  logic [127:0] ofm_bus = '0;
  logic         in_ready, wr_en, busy, done, overflow, cfg_err;
  logic [31:0]  wr_addr, wr_data;
`ifdef OFM_WB_CHECKSUM_EN
  logic [31:0]  checksum;
`endif

  ofm_writeback #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .OFM_W(cfg_w), .OFM_C(cfg_c), .in_valid(in_valid), .ofm_bus(ofm_bus),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow), .cfg_err(cfg_err)
`ifdef OFM_WB_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  logic [31:0] sb_base = '0;
  int          sb_c = 0, sb_np = 1, sb_total = 0, sb_acc = 0;
  int          n_wr = 0;
  logic [31:0] first_addr, first_data, last_addr;
  logic [31:0] cks_model = '0;

  // Expected words are formed when a pixel is accepted.
  always @(posedge clk) begin
    int g, p;
    wr_t e;
    if (rst_n && in_valid && in_ready && sb_acc < sb_total) begin
      g = sb_acc / sb_np;
      p = sb_acc % sb_np;
      for (int k = 0; k < 4; k++) begin
        e.addr = sb_base + 32'(p * (sb_c / 4)) + 32'(g * 4) + 32'(k);
        e.data = {ofm_bus[(4*k+3)*8 +: 8], ofm_bus[(4*k+2)*8 +: 8],
                  ofm_bus[(4*k+1)*8 +: 8], ofm_bus[(4*k)*8 +: 8]};
        sb_q.push_back(e);
      end
      sb_acc = sb_acc + 1;
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && wr_en) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wr", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        cks_model = {cks_model[30:0], cks_model[31]} ^ e.data;
      end
      if (n_wr == 0) begin
        first_addr = wr_addr;
        first_data = wr_data;
      end
      last_addr = wr_addr;
      n_wr++;
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [7:0] w, input logic [7:0] c);
    base_addr = b;
    cfg_w = w;
    cfg_c = c;
    start = 1'b1;
    if (c != 0 && c[3:0] == 0 && w != 0) begin
      sb_base = b;
      sb_c = int'(c);
      sb_np = int'(w) * int'(w);
      sb_total = (int'(c) / 16) * sb_np;
      sb_acc = 0;
      n_wr = 0;
      cks_model = '0;
      sb_q.delete();
    end
    @(negedge clk);
    start = 1'b0;
    // Scramble config inputs; the DUT must use the latched copy.
    base_addr = 32'hDEAD_BEEF;
    cfg_w = 8'd0;
    cfg_c = 8'd0;
  endtask

  task automatic send_pix(input logic [127:0] d);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    in_valid = 1'b1;
    ofm_bus = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  function automatic logic [127:0] ramp_pix(input int p);
    logic [127:0] d;
    for (int c = 0; c < 16; c++) d[c*8 +: 8] = 8'(16 * p + c);
    return d;
  endfunction

  function automatic logic [127:0] rand_pix();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_not_ready;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_rst");

    // Scenario 1: ramp pixels, single group
    do_start(32'h100, 8'd2, 8'd16);
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 1);
    send_pix(ramp_pix(0));
    check("t1_latency_wr_en", wr_en, 1);
    for (int p = 1; p < 4; p++) send_pix(ramp_pix(p));
    wait_done("t1");
    check("t1_n_wr", n_wr, 16);
    check("t1_sb_empty", sb_q.size(), 0);
    check("t1_first_addr", first_addr, 32'h100);
    check("t1_first_data", first_data, 32'h0302_0100);
    check("t1_last_addr", last_addr, 32'h10F);
    check("t1_busy_end", busy, 0);
`ifdef OFM_WB_CHECKSUM_EN
    check("t1_checksum", checksum, cks_model);
    repeat (3) @(negedge clk);
    check("t1_checksum_hold", checksum, cks_model);
`endif

    // Scenario 2: two channel groups, one pixel each
    do_start(32'h200, 8'd1, 8'd32);
    send_pix(rand_pix());
    send_pix(rand_pix());
    wait_done("t2");
    check("t2_n_wr", n_wr, 8);
    check("t2_last_addr", last_addr, 32'h207);
    check("t2_busy", busy, 0);
    in_valid = 1'b1;
    ofm_bus = rand_pix();
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("t2_ovf_in_done", overflow, 0);

    // Scenario 3: hold in_valid for 8 cycles against a 4-deep FIFO
    do_start(32'h40, 8'd4, 8'd16);
    saw_not_ready = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      ofm_bus = rand_pix();
      if (!in_ready) saw_not_ready = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t3_saw_not_ready", saw_not_ready, 1);
    check("t3_overflow", overflow, 1);
    check("t3_accepted", sb_acc, 6);
    for (int i = 0; i < 16 && sb_acc < 16; i++) send_pix(rand_pix());
    wait_done("t3");
    check("t3_n_wr", n_wr, 64);
    check("t3_sb_empty", sb_q.size(), 0);
    check("t3_overflow_sticky", overflow, 1);

    // Scenario 4: bad channel count, then a valid restart
    do_start(32'h0, 8'd1, 8'd20);
    check("t4_cfg_err", cfg_err, 1);
    check("t4_busy", busy, 0);
    check("t4_in_ready", in_ready, 0);
    repeat (4) @(negedge clk);
    do_start(32'h80, 8'd1, 8'd16);
    check("t4_cfg_err_clr", cfg_err, 0);
    check("t4_busy_run", busy, 1);
    check("t4_overflow_clr", overflow, 0);
    send_pix(rand_pix());
    in_valid = 1'b1;
    ofm_bus = rand_pix();
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_ovf_excess", overflow, 1);
    wait_done("t4");
    check("t4_n_wr", n_wr, 4);
    check("t4_last_addr", last_addr, 32'h83);

    // Scenario 5: reset during the k=2 word
    do_start(32'h300, 8'd2, 8'd16);
    send_pix(rand_pix());
    repeat (2) @(negedge clk);
    check("t5_wr_en_k2", wr_en, 1);
    check("t5_addr_k2", wr_addr, 32'h302);
    #1 rst_n = 1'b0;
    #1 check("t5_wr_en_async", wr_en, 0);
    check_idle_outputs("t5_in_rst");
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_post_rst");
    do_start(32'h300, 8'd2, 8'd16);
    for (int p = 0; p < 4; p++) send_pix(ramp_pix(p));
    wait_done("t5");
    check("t5_n_wr", n_wr, 16);
    check("t5_last_addr", last_addr, 32'h30F);
    check("t5_sb_empty", sb_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
